imem_loadable: RTL and testbench

- Parametrised, loadable instruction memory for the RISC-V core; replaces the fixed, hard-initialised combinational instruction ROM.
- Programs are written word-by-word through a load port while the core is held in LOAD mode. After load, the block serves fetches with 1-cycle synchronous read latency.
- Detects misaligned and out-of-range fetch addresses, returning a NOP plus a fault flag.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_loadable_if.sv | 34 +++
 rtl/imem_sram_1r1w.sv | 36 +++
 rtl/imem_loadable.sv | 103 ++++++++++
 tb/tb_imem_loadable.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg : shared types, constants and fetch-legality helper         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package imem_pkg;

  typedef enum logic [0:0] {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Word-aligned and word index below depth; addr is the zero-extended PC.
  function automatic logic is_fetch_legal(input logic [63:0] addr, input int depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loadable_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loadable_if : load, control and fetch bundle of imem_loadable   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface imem_loadable_if #(
  parameter int ADDR_W = 32,
  parameter int INS_W  = 32,
  parameter int IDX_W  = 6
);
  logic              load_we;
  logic [IDX_W-1:0]  load_addr;
  logic [INS_W-1:0]  load_data;
  logic              load_done;
  logic              reload;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [INS_W-1:0]  instruction;
  logic              fetch_fault;
  logic              run_mode;
  logic [IDX_W:0]    words_loaded;

  modport slave (
    input  load_we, load_addr, load_data, load_done, reload, fetch_req, fetch_addr,
    output fetch_valid, instruction, fetch_fault, run_mode, words_loaded
  );

  modport master (
    output load_we, load_addr, load_data, load_done, reload, fetch_req, fetch_addr,
    input  fetch_valid, instruction, fetch_fault, run_mode, words_loaded
  );
endinterface
`default_nettype wire

// File: rtl/imem_sram_1r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_sram_1r1w : 1-write/1-read synchronous array, registered read   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module imem_sram_1r1w #(
  parameter int INS_W = 32,
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [INS_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [INS_W-1:0] rdata
);

  logic [INS_W-1:0] mem [DEPTH];
  logic [INS_W-1:0] rdata_q;

  // No reset so the array and its output register map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loadable : loadable instruction memory, LOAD/RUN FSM, 1-cycle   |
// |                 synchronous fetch with misalign/range fault          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module imem_loadable
  import imem_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               INS_W     = 32,
  parameter int               DEPTH     = 64,
  parameter logic [INS_W-1:0] NOP_INSTR = INS_W'(RV_NOP)
) (
  input  logic           clk,
  input  logic           reset,
  imem_loadable_if.slave bus
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam int               CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  imem_state_t      state_q, state_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             mem_we;
  logic             mem_re;
  logic             fetch_legal;
  logic [IDX_W-1:0] rd_idx;
  logic [INS_W-1:0] rd_data;

  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    valid_d     = 1'b0;
    fault_d     = fault_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    fetch_legal = is_fetch_legal(64'(bus.fetch_addr), DEPTH);
    rd_idx      = bus.fetch_addr[IDX_W+1:2];
    case (state_q)
      IMEM_LOAD: begin
        mem_we = bus.load_we;
        if (bus.load_we && (words_q != CNT_MAX)) begin
          words_d = words_q + CNT_W'(1);
        end
        if (bus.load_done) begin
          state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        // reload has priority: a fetch in the same cycle is dropped.
        if (bus.reload) begin
          state_d = IMEM_LOAD;
          words_d = '0;
        end else if (bus.fetch_req) begin
          valid_d = 1'b1;
          fault_d = !fetch_legal;
          mem_re  = fetch_legal;
        end
      end
      default: state_d = IMEM_LOAD;
    endcase
  end

  // fault_q resets high so the output mux presents NOP while rd_data is unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IMEM_LOAD;
      words_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b1;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  imem_sram_1r1w #(
    .INS_W (INS_W),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .re    (mem_re),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign bus.fetch_valid  = valid_q;
  assign bus.fetch_fault  = valid_q & fault_q;
  assign bus.instruction  = fault_q ? NOP_INSTR : rd_data;
  assign bus.run_mode     = (state_q == IMEM_RUN);
  assign bus.words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loadable : directed scoreboard bench for imem_loadable       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_imem_loadable;
  import imem_pkg::*;

  localparam int          ADDR_W = 32;
  localparam int          INS_W  = 32;
  localparam int          DEPTH  = 64;
  localparam int          IDX_W  = 6;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loadable_if #(.ADDR_W(ADDR_W), .INS_W(INS_W), .IDX_W(IDX_W)) bus ();

  imem_loadable #(
    .ADDR_W    (ADDR_W),
    .INS_W     (INS_W),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        fault;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [DEPTH];
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_instr;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.load_we    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_done  = 1'b0;
    bus.reload     = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".run_mode"}, 64'(bus.run_mode), 64'(m_run));
    chk({tag, ".words"}, 64'(bus.words_loaded), 64'(m_cnt));
    chk({tag, ".instr"}, 64'(bus.instruction), 64'(m_instr));
  endtask

  // One clock: predict from current inputs, advance reference, compare after edge.
  task automatic step(input string tag);
    exp_t        e;
    bit          acc;
    bit          legal;
    logic [31:0] a;
    a     = bus.fetch_addr;
    acc   = m_run && bus.fetch_req && !bus.reload;
    legal = (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    e.valid = acc;
    e.fault = acc && !legal;
    e.instr = m_instr;
    if (acc) e.instr = legal ? model[int'(a >> 2)] : NOP;
    sb_q.push_back(e);
    if (!m_run) begin
      if (bus.load_we) begin
        model[bus.load_addr] = bus.load_data;
        if (m_cnt < DEPTH) m_cnt++;
      end
      if (bus.load_done) m_run = 1'b1;
    end else if (bus.reload) begin
      m_run = 1'b0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    e       = sb_q.pop_front();
    m_instr = e.instr;
    chk({tag, ".valid"}, 64'(bus.fetch_valid), 64'(e.valid));
    chk({tag, ".fault"}, 64'(bus.fetch_fault), 64'(e.fault));
    check_outputs(tag);
  endtask

  task automatic load(input int idx, input logic [31:0] data, input bit done);
    bus.load_we   = 1'b1;
    bus.load_addr = IDX_W'(idx);
    bus.load_data = data;
    bus.load_done = done;
  endtask

  task automatic fetch(input logic [31:0] addr);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
  endtask

  initial begin
    idle_inputs();
    reset   = 1'b1;
    m_run   = 1'b0;
    m_cnt   = 0;
    m_instr = NOP;
    #1;
    chk("reset.valid", 64'(bus.fetch_valid), 64'(0));
    chk("reset.fault", 64'(bus.fetch_fault), 64'(0));
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    load(0, 32'h0020_0093, 1'b0); step("load0");
    load(1, 32'h0010_0113, 1'b0); step("load1");
    load(2, 32'h00E0_8367, 1'b1); step("load2_done");
    idle_inputs();

    fetch(32'h0); step("fetch0");
    fetch(32'h4); step("fetch4");
    fetch(32'h8); step("fetch8");
    idle_inputs(); step("hold_after_fetch");

    fetch(32'h6);   step("misaligned");
    fetch(32'h100); step("out_of_range");
    idle_inputs();  step("hold_after_fault");

    load(0, 32'hFFFF_FFFF, 1'b0); step("load_in_run");
    idle_inputs();
    fetch(32'h0); step("fetch0_unchanged");
    idle_inputs(); step("idle_run");

    bus.reload = 1'b1; fetch(32'h0); step("reload_with_fetch");
    idle_inputs();
    fetch(32'h0); step("fetch_in_load");
    idle_inputs();

    for (int i = 0; i <= DEPTH; i++) begin
      load(i % DEPTH, ((i % DEPTH) == 0) ? 32'h0050_0293 : (32'hA000_0000 + 32'(i)), i == DEPTH);
      step($sformatf("sat_load%0d", i));
    end
    idle_inputs();
    fetch(32'h0);   step("fetch_new0");
    fetch(32'hFC);  step("fetch_last");
    fetch(32'h100); step("fetch_past_end");
    idle_inputs();  step("idle_after_sat");

    fetch(32'h4); step("pre_reset_fetch");
    #1 reset = 1'b1;
    #1;
    sb_q.delete();
    m_run   = 1'b0;
    m_cnt   = 0;
    m_instr = NOP;
    chk("midreset.valid", 64'(bus.fetch_valid), 64'(0));
    chk("midreset.fault", 64'(bus.fetch_fault), 64'(0));
    check_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    step("post_reset_fetch_ignored");
    bus.load_done = 1'b1; step("post_reset_done");
    bus.load_done = 1'b0;
    fetch(32'h0); step("post_reset_fetch0");
    idle_inputs(); step("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
